// File: rtl/weight_load_ctrl_if.sv
// weight_load_ctrl_if: control, memory-read and buffer-load signals of the weight loader
interface weight_load_ctrl_if;
  logic        start;
  logic        start_mode;
  logic [15:0] base_addr;
  logic        compute_idle;
  logic        busy;
  logic        done;
  logic        mem_rd_en;
  logic [15:0] mem_addr;
  logic        mem_rd_valid;
  logic [31:0] mem_rd_data;
  logic        mode;
  logic        conv_load_en;
  logic [3:0]  conv_load_pe_idx;
  logic [31:0] conv_load_data;
  logic        conv_bias_load_en;
  logic [31:0] conv_bias_load_data;
  logic        mlp_load_en;
  logic [6:0]  mlp_load_k_word;
  logic [31:0] mlp_load_data;
  logic        swap;
  modport master (
    input  start, start_mode, base_addr, compute_idle, mem_rd_valid, mem_rd_data,
    output busy, done, mem_rd_en, mem_addr, mode, conv_load_en, conv_load_pe_idx,
           conv_load_data, conv_bias_load_en, conv_bias_load_data, mlp_load_en,
           mlp_load_k_word, mlp_load_data, swap
  );
  modport slave (
    output start, start_mode, base_addr, compute_idle, mem_rd_valid, mem_rd_data,
    input  busy, done, mem_rd_en, mem_addr, mode, conv_load_en, conv_load_pe_idx,
           conv_load_data, conv_bias_load_en, conv_bias_load_data, mlp_load_en,
           mlp_load_k_word, mlp_load_data, swap
  );
endinterface

// File: rtl/weight_load_ctrl.sv
// weight_load_ctrl: fetches conv or MLP weight words one read at a time into the shadow bank, then swaps banks
module weight_load_ctrl #(
  parameter int N_PE      = 12,
  parameter int N_TAP     = 4,
  parameter int MAX_BYTES = 384
) (
  input logic               clk,
  input logic               rst_n,
  weight_load_ctrl_if.master bus
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, SWAP_WAIT} state_t;
  localparam logic [6:0] CONV_LAST = 7'(N_PE);
  localparam logic [6:0] MLP_LAST  = 7'(MAX_BYTES / N_TAP - 1);
  state_t      state_q, state_d;
  logic        mode_q;
  logic [15:0] base_q;
  logic [6:0]  idx_q;
  logic        conv_en_q, bias_en_q, mlp_en_q, swap_q;
  logic [3:0]  pe_idx_q;
  logic [6:0]  k_word_q;
  logic [31:0] conv_data_q, bias_data_q, mlp_data_q;
  logic        accept, capture, last_word, conv_hit, bias_hit, mlp_hit;
  assign accept    = state_q == IDLE && bus.start;
  assign capture   = state_q == WAIT && bus.mem_rd_valid;
  assign last_word = idx_q == (mode_q ? MLP_LAST : CONV_LAST);
  assign conv_hit  = capture && !mode_q && idx_q < CONV_LAST;
  assign bias_hit  = capture && !mode_q && last_word;
  assign mlp_hit   = capture && mode_q;
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  // next state: one request, wait for its data, repeat until the last word, then wait for the consumer
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      state_d = bus.start ? REQ : IDLE;
      REQ:       state_d = WAIT;
      WAIT:      state_d = !bus.mem_rd_valid ? WAIT : last_word ? SWAP_WAIT : REQ;
      SWAP_WAIT: state_d = bus.compute_idle ? IDLE : SWAP_WAIT;
      default:   state_d = IDLE;
    endcase
  end
  // load context latched on an accepted start; index advances on every non-final capture
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mode_q <= 1'b0;
      base_q <= '0;
      idx_q  <= '0;
    end else if (accept) begin
      mode_q <= bus.start_mode;
      base_q <= bus.base_addr;
      idx_q  <= '0;
    end else if (capture && !last_word) begin
      idx_q  <= idx_q + 7'd1;
    end
  // registered buffer strobes and swap pulse; address/data hold between strobes
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      conv_en_q   <= 1'b0;
      bias_en_q   <= 1'b0;
      mlp_en_q    <= 1'b0;
      swap_q      <= 1'b0;
      pe_idx_q    <= '0;
      k_word_q    <= '0;
      conv_data_q <= '0;
      bias_data_q <= '0;
      mlp_data_q  <= '0;
    end else begin
      conv_en_q <= conv_hit;
      bias_en_q <= bias_hit;
      mlp_en_q  <= mlp_hit;
      swap_q    <= state_q == SWAP_WAIT && bus.compute_idle;
      if (conv_hit) begin
        pe_idx_q    <= idx_q[3:0];
        conv_data_q <= bus.mem_rd_data;
      end
      if (bias_hit) bias_data_q <= bus.mem_rd_data;
      if (mlp_hit) begin
        k_word_q   <= idx_q;
        mlp_data_q <= bus.mem_rd_data;
      end
    end
  // outputs decoded from state and registers
  always_comb begin
    bus.busy                = state_q != IDLE;
    bus.mem_rd_en           = state_q == REQ;
    bus.mem_addr            = base_q + 16'(idx_q);
    bus.mode                = mode_q;
    bus.conv_load_en        = conv_en_q;
    bus.conv_load_pe_idx    = pe_idx_q;
    bus.conv_load_data      = conv_data_q;
    bus.conv_bias_load_en   = bias_en_q;
    bus.conv_bias_load_data = bias_data_q;
    bus.mlp_load_en         = mlp_en_q;
    bus.mlp_load_k_word     = k_word_q;
    bus.mlp_load_data       = mlp_data_q;
    bus.swap                = swap_q;
    bus.done                = swap_q;
  end
endmodule

// File: tb/tb_weight_load_ctrl.sv
// tb_weight_load_ctrl: directed checks of conv/MLP loads, wrap, stalls, ignored inputs and mid-load reset
module tb_weight_load_ctrl;
  typedef struct packed {
    logic [1:0]  kind;
    logic [6:0]  idx;
    logic [31:0] data;
  } ev_t;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pend = 1'b0;
  logic        stray = 1'b0;
  logic        exp_mode = 1'b0;
  logic [15:0] paddr = '0;
  int          lat = 1;
  int          cnt = 0;
  int          n_chk = 0;
  int          n_pass = 0;
  int          run_no = 0;
  int          seen_run = 0;
  int          swap_n = 0;
  int          mode_err = 0;
  int          multi_n = 0;
  ev_t         ev_q[$];
  logic [15:0] addr_q[$];
  always #5 clk = ~clk;
  weight_load_ctrl_if wif();
  weight_load_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(wif));
  function automatic logic [31:0] mdata(input logic [15:0] a);
    return {a, ~a};
  endfunction
  always @(posedge clk)
    if (!rst_n) pend <= 1'b0;
    else if (wif.mem_rd_en) begin
      pend  <= 1'b1;
      cnt   <= lat - 1;
      paddr <= wif.mem_addr;
    end else if (pend) begin
      if (cnt == 0) pend <= 1'b0;
      else cnt <= cnt - 1;
    end
  assign wif.mem_rd_valid = (pend && cnt == 0) || stray;
  assign wif.mem_rd_data  = mdata(paddr);
  always @(negedge clk) begin
    if (run_no != seen_run) begin
      ev_q.delete();
      addr_q.delete();
      swap_n   <= 0;
      mode_err <= 0;
      multi_n  <= 0;
      seen_run <= run_no;
    end
    if (rst_n) begin
      if (wif.mem_rd_en) addr_q.push_back(wif.mem_addr);
      if (wif.conv_load_en) ev_q.push_back({2'd1, 3'd0, wif.conv_load_pe_idx, wif.conv_load_data});
      if (wif.conv_bias_load_en) ev_q.push_back({2'd2, 7'd0, wif.conv_bias_load_data});
      if (wif.mlp_load_en) ev_q.push_back({2'd3, wif.mlp_load_k_word, wif.mlp_load_data});
      if (wif.swap) swap_n <= swap_n + 1;
      if (int'(wif.conv_load_en) + int'(wif.conv_bias_load_en) + int'(wif.mlp_load_en) > 1) multi_n <= multi_n + 1;
      if (wif.busy && wif.mode !== exp_mode) mode_err <= mode_err + 1;
    end
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask
  task automatic tick();
    @(negedge clk);
    #1;
  endtask
  task automatic zero_outs(input string tag);
    check({tag, "_mode"}, wif.mode, 0);
    check({tag, "_busy"}, wif.busy, 0);
    check({tag, "_done"}, wif.done, 0);
    check({tag, "_rd_en"}, wif.mem_rd_en, 0);
    check({tag, "_addr"}, wif.mem_addr, 0);
    check({tag, "_conv_en"}, wif.conv_load_en, 0);
    check({tag, "_pe_idx"}, wif.conv_load_pe_idx, 0);
    check({tag, "_conv_data"}, wif.conv_load_data, 0);
    check({tag, "_bias_en"}, wif.conv_bias_load_en, 0);
    check({tag, "_bias_data"}, wif.conv_bias_load_data, 0);
    check({tag, "_mlp_en"}, wif.mlp_load_en, 0);
    check({tag, "_k_word"}, wif.mlp_load_k_word, 0);
    check({tag, "_mlp_data"}, wif.mlp_load_data, 0);
    check({tag, "_swap"}, wif.swap, 0);
  endtask
  task automatic launch(input logic m, input logic [15:0] b, input int l);
    exp_mode = m;
    lat = l;
    run_no++;
    wif.start_mode = m;
    wif.base_addr = b;
    wif.start = 1'b1;
    tick();
    wif.start = 1'b0;
  endtask
  task automatic wait_strobes(input int n);
    for (int i = 0; i < 5000 && ev_q.size() < n; i++) tick();
    check("strobe_wait", ev_q.size(), n);
  endtask
  task automatic finish_load();
    for (int i = 0; i < 2000 && !wif.done; i++) tick();
    check("done", wif.done, 1);
    check("swap_with_done", wif.swap, 1);
    check("busy_at_done", wif.busy, 0);
    tick();
    check("done_single", wif.done, 0);
    check("swap_single", wif.swap, 0);
  endtask
  task automatic verify(input logic m, input logic [15:0] b, input int n);
    logic [15:0] a;
    check("n_reads", addr_q.size(), n);
    check("n_strobes", ev_q.size(), n);
    for (int i = 0; i < n && i < addr_q.size(); i++) begin
      a = b + 16'(i);
      check("rd_addr", addr_q[i], a);
    end
    for (int i = 0; i < n && i < ev_q.size(); i++) begin
      a = b + 16'(i);
      check("kind", ev_q[i].kind, m ? 2'd3 : (i < 12 ? 2'd1 : 2'd2));
      check("index", ev_q[i].idx, (m || i < 12) ? i : 0);
      check("data", ev_q[i].data, mdata(a));
    end
    check("swap_count", swap_n, 1);
    check("mode_stable", mode_err, 0);
    check("multi_strobe", multi_n, 0);
    check("mode_after", wif.mode, m);
  endtask
  initial begin
    int n0;
    wif.start = 1'b0;
    wif.start_mode = 1'b0;
    wif.base_addr = '0;
    wif.compute_idle = 1'b1;
    tick();
    tick();
    zero_outs("reset");
    rst_n = 1'b1;
    tick();
    launch(1'b0, 16'h0100, 1);
    finish_load();
    verify(1'b0, 16'h0100, 13);
    check("conv_last_addr", addr_q.size() > 12 ? addr_q[12] : 16'hDEAD, 16'h010C);
    launch(1'b1, 16'h2000, 3);
    finish_load();
    verify(1'b1, 16'h2000, 96);
    check("mlp_last_k", ev_q.size() > 95 ? ev_q[95].idx : 7'h7F, 95);
    wif.compute_idle = 1'b0;
    launch(1'b0, 16'h0400, 1);
    wait_strobes(13);
    repeat (20) tick();
    check("stall_no_swap", swap_n, 0);
    check("stall_busy", wif.busy, 1);
    check("stall_swap_now", wif.swap, 0);
    wif.compute_idle = 1'b1;
    tick();
    check("release_swap", wif.swap, 1);
    check("release_done", wif.done, 1);
    tick();
    check("release_swap_off", wif.swap, 0);
    check("release_busy", wif.busy, 0);
    verify(1'b0, 16'h0400, 13);
    n0 = ev_q.size();
    stray = 1'b1;
    tick();
    tick();
    stray = 1'b0;
    tick();
    check("stray_valid_ev", ev_q.size(), n0);
    check("stray_valid_busy", wif.busy, 0);
    launch(1'b0, 16'h0800, 3);
    wait_strobes(3);
    for (int i = 0; i < 50 && !wif.mem_rd_en; i++) tick();
    check("found_req", wif.mem_rd_en, 1);
    tick();
    wif.start_mode = 1'b1;
    wif.base_addr = 16'h5555;
    wif.start = 1'b1;
    tick();
    wif.start = 1'b0;
    finish_load();
    verify(1'b0, 16'h0800, 13);
    launch(1'b0, 16'hFFF8, 1);
    finish_load();
    verify(1'b0, 16'hFFF8, 13);
    check("wrap_7", addr_q.size() > 7 ? addr_q[7] : 16'hDEAD, 16'hFFFF);
    check("wrap_8", addr_q.size() > 8 ? addr_q[8] : 16'hDEAD, 16'h0000);
    check("wrap_12", addr_q.size() > 12 ? addr_q[12] : 16'hDEAD, 16'h0004);
    launch(1'b1, 16'h3000, 3);
    wait_strobes(40);
    check("mid_busy", wif.busy, 1);
    rst_n = 1'b0;
    #1;
    zero_outs("mid_reset");
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    check("mid_no_swap", swap_n, 0);
    check("mid_idle", wif.busy, 0);
    launch(1'b1, 16'h3000, 3);
    finish_load();
    verify(1'b1, 16'h3000, 96);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/weight_load_ctrl.md
WEIGHT_LOAD_CTRL -- requirements
Module: weight_load_ctrl

Interface
REQ-001 SHALL have parameter N_PE, default 12, number of PEs (conv weight words per load).
REQ-002 SHALL have parameter N_TAP, default 4, bytes per 32-bit weight word.
REQ-003 SHALL have parameter MAX_BYTES, default 384, weight bank depth in bytes; MLP word count = MAX_BYTES/N_TAP (96).
REQ-004 SHALL have one clock and an asynchronous active-low reset: clk  input  1  clock; rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have these control ports: start  input  1  load request pulse; start_mode  input  1  0=conv, 1=MLP; base_addr  input  16  first weight-memory word address; compute_idle  input  1  consumer no longer reads the active bank; busy  output  1  load in progress; done  output  1  one-cycle completion pulse.
REQ-006 SHALL have these memory read ports: mem_rd_en  output  1  one-cycle read request; mem_addr  output  16  word address; mem_rd_valid  input  1  read data valid; mem_rd_data  input  32  read data.
REQ-007 SHALL have these buffer-side ports: mode  output  1; conv_load_en  output  1; conv_load_pe_idx  output  4; conv_load_data  output  32; conv_bias_load_en  output  1; conv_bias_load_data  output  32; mlp_load_en  output  1; mlp_load_k_word  output  7; mlp_load_data  output  32; swap  output  1.

Function
REQ-008 SHALL implement FSM states IDLE, REQ, WAIT, SWAP_WAIT.
REQ-009 In IDLE, start=1 SHALL latch start_mode into mode, latch base_addr, clear word index, and go to REQ; start=0 SHALL hold IDLE.
REQ-010 start SHALL be ignored in all states other than IDLE.
REQ-011 mode SHALL change only on an accepted start and SHALL otherwise hold its value, including after done.
REQ-012 Word count SHALL be N_PE+1 (13) in conv mode and MAX_BYTES/N_TAP (96) in MLP mode.
REQ-013 In REQ, the block SHALL assert mem_rd_en for exactly one cycle, drive mem_addr = base_addr + index (16-bit wrap-around), and go to WAIT.
REQ-014 At most one read SHALL be outstanding; mem_rd_en SHALL be 0 in every state except REQ.
REQ-015 In WAIT, mem_rd_valid=1 SHALL capture mem_rd_data and assert exactly one load strobe, registered, in the following cycle.
REQ-016 The conv strobe mapping SHALL be: index 0..N_PE-1 -> conv_load_en=1, conv_load_pe_idx=index, conv_load_data=data; index N_PE -> conv_bias_load_en=1, conv_bias_load_data=data.
REQ-017 The MLP strobe mapping SHALL be: mlp_load_en=1, mlp_load_k_word=index, mlp_load_data=data.
REQ-018 After capture, the FSM SHALL go to REQ with index+1, or to SWAP_WAIT if index was the last word.
REQ-019 Strobes SHALL be single-cycle; strobe address and data outputs SHALL hold their last value when the strobe is 0.
REQ-020 mem_rd_valid SHALL be ignored outside WAIT.
REQ-021 In SWAP_WAIT, compute_idle=1 SHALL produce swap=1 and done=1 for one registered cycle, then return to IDLE; compute_idle=0 SHALL hold SWAP_WAIT indefinitely.
REQ-022 swap SHALL assert no earlier than one cycle after the last load strobe.
REQ-023 busy SHALL be 1 in REQ, WAIT and SWAP_WAIT, and 0 in IDLE.

Reset
REQ-024 rst_n=0 SHALL immediately force IDLE and drive every output (mode, busy, done, mem_rd_en, mem_addr, all strobes, indices, data, swap) to 0.
REQ-025 A reset mid-load SHALL abandon the load with no swap; a later start SHALL restart from index 0.

Verification
REQ-026 Conv, base 0x0100, 1-cycle memory latency, compute_idle=1 -> 13 reads at 0x0100..0x010C; pe_idx 0..11 with matching data; then bias strobe carrying word 12; then one swap+done pulse; busy drops.
REQ-027 MLP, base 0x2000, 3-cycle latency -> 96 mlp_load_en pulses with k_word 0..95 in order; no conv or bias strobes; mode=1 throughout.
REQ-028 compute_idle held 0 for 20 cycles after the last strobe -> swap stays 0 and busy stays 1; swap asserts the cycle after compute_idle rises.
REQ-029 start pulsed during WAIT, plus mem_rd_valid pulsed in IDLE -> both ignored; the sequence, addresses and strobe count are unchanged.
REQ-030 Conv, base 0xFFF8 -> addresses 0xFFF8..0xFFFF then 0x0000..0x0004.
REQ-031 rst_n pulsed low during MLP word 40 -> all outputs 0 at once with no swap; a new start completes all 96 words from k_word 0.
